// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: button indices, repeat-FSM
// states and a counter-width helper.
package button_conditioner_pkg;

  localparam int unsigned NUM_BTNS = 7;
  localparam int unsigned NUM_DIRS = 4;

  // Values are the bit positions of each button in the held vector (MSB = start)
  typedef enum logic [2:0] {
    BTN_START = 3'd6,
    BTN_A     = 3'd5,
    BTN_B     = 3'd4,
    BTN_UP    = 3'd3,
    BTN_DOWN  = 3'd2,
    BTN_LEFT  = 3'd1,
    BTN_RIGHT = 3'd0
  } btn_idx_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to hold values up to max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : unsigned'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// Per-button front end: polarity fix-up, 2-flop synchronizer, debounce
// counter and rising-edge detect of the debounced level.
module btn_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          RAW_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_in;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_prev;

  // Normalise pin polarity so that 1 always means pressed
  always_comb raw_in = RAW_ACTIVE_LOW ? ~raw : raw;

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], raw_in};
  end

  // Level flips once the synchronized input has disagreed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One-cycle indication that the debounced level has just risen
  always_comb rise = level & ~level_prev;

endmodule

// File: rtl/button_conditioner.sv
// Conditions seven raw board buttons into debounced levels and registered
// single-cycle press pulses, with auto-repeat and priority on the directions.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  parameter bit          RAW_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_start,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_up,
  input  logic       raw_down,
  input  logic       raw_left,
  input  logic       raw_right,
  output logic       start_button,
  output logic       a_button,
  output logic       b_button,
  output logic       up_button,
  output logic       down_button,
  output logic       left_button,
  output logic       right_button,
  output logic [6:0] held
);

  localparam int unsigned   RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   RW         = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [NUM_BTNS-1:0] raw_vec;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_DIRS-1:0] fire;
  rpt_state_e          rpt_state [NUM_DIRS];
  logic [RW-1:0]       rpt_cnt   [NUM_DIRS];

  // Reset asserts immediately and releases two clock edges after the pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb rst_n = rst_sync[1];

  // Pins gathered in held-vector order, MSB = start
  always_comb raw_vec = {raw_start, raw_a, raw_b, raw_up, raw_down, raw_left, raw_right};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  always_comb held = level;

  // Direction d wants to pulse this cycle: on press, at end of delay, at each repeat
  always_comb begin
    fire = '0;
    for (int unsigned d = 0; d < NUM_DIRS; d++) begin
      case (rpt_state[d])
        RPT_IDLE:   fire[d] = rise[d];
        RPT_DELAY:  fire[d] = level[d] && (rpt_cnt[d] == DELAY_LAST);
        RPT_REPEAT: fire[d] = level[d] && (rpt_cnt[d] == RATE_LAST);
        default:    fire[d] = 1'b0;
      endcase
    end
  end

  // Per-direction repeat FSMs; release returns to IDLE with the counter cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < NUM_DIRS; d++) begin
        rpt_state[d] <= RPT_IDLE;
        rpt_cnt[d]   <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < NUM_DIRS; d++) begin
        if (!level[d]) begin
          rpt_state[d] <= RPT_IDLE;
          rpt_cnt[d]   <= '0;
        end else begin
          case (rpt_state[d])
            RPT_IDLE: begin
              if (rise[d]) begin
                rpt_state[d] <= RPT_DELAY;
                rpt_cnt[d]   <= '0;
              end
            end
            RPT_DELAY: begin
              if (rpt_cnt[d] == DELAY_LAST) begin
                rpt_state[d] <= RPT_REPEAT;
                rpt_cnt[d]   <= '0;
              end else if (rpt_cnt[d] != '1) begin
                rpt_cnt[d] <= rpt_cnt[d] + 1'b1;
              end
            end
            RPT_REPEAT: begin
              if (rpt_cnt[d] == RATE_LAST)  rpt_cnt[d] <= '0;
              else if (rpt_cnt[d] != '1)    rpt_cnt[d] <= rpt_cnt[d] + 1'b1;
            end
            default: begin
              rpt_state[d] <= RPT_IDLE;
              rpt_cnt[d]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Registered pulses; directions go through a fixed-priority mux, losers are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_button <= 1'b0;
      a_button     <= 1'b0;
      b_button     <= 1'b0;
      up_button    <= 1'b0;
      down_button  <= 1'b0;
      left_button  <= 1'b0;
      right_button <= 1'b0;
    end else begin
      start_button <= rise[BTN_START];
      a_button     <= rise[BTN_A];
      b_button     <= rise[BTN_B];
      up_button    <= fire[2'(BTN_UP)];
      down_button  <= fire[2'(BTN_DOWN)] & ~fire[2'(BTN_UP)];
      left_button  <= fire[2'(BTN_LEFT)] & ~fire[2'(BTN_UP)] & ~fire[2'(BTN_DOWN)];
      right_button <= fire[2'(BTN_RIGHT)] & ~fire[2'(BTN_UP)] & ~fire[2'(BTN_DOWN)]
                      & ~fire[2'(BTN_LEFT)];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=8; a second instance uses active-low pins.
module tb_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 8;

  logic clk = 1'b0;
  logic reset;
  logic raw_start, raw_a, raw_b, raw_up, raw_down, raw_left, raw_right;
  logic start_button, a_button, b_button, up_button, down_button, left_button, right_button;
  logic [6:0] held;
  logic [6:0] pulses;

  logic al_start, al_a, al_b, al_up, al_down, al_left, al_right;
  logic al_start_btn, al_a_btn, al_b_btn, al_up_btn, al_down_btn, al_left_btn, al_right_btn;
  logic [6:0] al_held;
  logic [6:0] al_pulses;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RAW_ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset),
    .raw_start(raw_start), .raw_a(raw_a), .raw_b(raw_b), .raw_up(raw_up),
    .raw_down(raw_down), .raw_left(raw_left), .raw_right(raw_right),
    .start_button(start_button), .a_button(a_button), .b_button(b_button),
    .up_button(up_button), .down_button(down_button), .left_button(left_button),
    .right_button(right_button), .held(held)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RAW_ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .reset(reset),
    .raw_start(al_start), .raw_a(al_a), .raw_b(al_b), .raw_up(al_up),
    .raw_down(al_down), .raw_left(al_left), .raw_right(al_right),
    .start_button(al_start_btn), .a_button(al_a_btn), .b_button(al_b_btn),
    .up_button(al_up_btn), .down_button(al_down_btn), .left_button(al_left_btn),
    .right_button(al_right_btn), .held(al_held)
  );

  always #5 clk = ~clk;

  always_comb pulses = {start_button, a_button, b_button, up_button,
                        down_button, left_button, right_button};
  always_comb al_pulses = {al_start_btn, al_a_btn, al_b_btn, al_up_btn,
                           al_down_btn, al_left_btn, al_right_btn};

  // Advance to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input int e, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_pulses", i, pulses, 7'b0);
      chk("idle_al_pulses", i, al_pulses, 7'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    {raw_start, raw_a, raw_b, raw_up, raw_down, raw_left, raw_right} = '0;
    {al_start, al_a, al_b, al_up, al_down, al_left, al_right} = '1;
    #1 reset = 1'b0;
    #2;
    chk("rst_pulses", 0, pulses, 7'b0);
    chk("rst_held", 0, held, 7'b0);
    chk("rst_al_pulses", 0, al_pulses, 7'b0);
    chk("rst_al_held", 0, al_held, 7'b0);
    repeat (3) tick();
    reset = 1'b1;
    idle(6);

    // a: high from edge 10 for 50 cycles -> one pulse at 16, held[5] over [15,64]
    for (int e = 0; e < 80; e++) begin
      raw_a = (e >= 10 && e < 60);
      tick();
      chk("a_pulse", e, pulses, (e == 16) ? 7'b0100000 : 7'b0);
      chk("a_held", e, held, (e >= 15 && e <= 64) ? 7'b0100000 : 7'b0);
    end
    idle(4);

    // up: 3-cycle glitch -> nothing
    for (int e = 0; e < 20; e++) begin
      raw_up = (e < 3);
      tick();
      chk("glitch_pulse", e, pulses, 7'b0);
      chk("glitch_held", e, held, 7'b0);
    end
    idle(4);

    // right: 60 cycles from edge 0 -> press, delay, then repeat pulses
    for (int e = 0; e < 80; e++) begin
      raw_right = (e < 60);
      tick();
      chk("right_pulse", e, pulses,
          ((e == 6) || (e == 26) || (e == 34) || (e == 42) || (e == 50) || (e == 58))
          ? 7'b0000001 : 7'b0);
      chk("right_held", e, held, (e >= 5 && e <= 64) ? 7'b0000001 : 7'b0);
    end
    idle(4);

    // up + left together for 28 cycles -> only up pulses (6 and 26); left dropped
    for (int e = 0; e < 45; e++) begin
      raw_up   = (e < 28);
      raw_left = (e < 28);
      tick();
      chk("prio_pulse", e, pulses, ((e == 6) || (e == 26)) ? 7'b0001000 : 7'b0);
      chk("prio_held", e, held, (e >= 5 && e <= 32) ? 7'b0001010 : 7'b0);
    end
    idle(4);

    // down held across a reset pulse asserted before edge 15 for 3 edges
    for (int e = 0; e < 15; e++) begin
      raw_down = 1'b1;
      tick();
      chk("down_pre_pulse", e, pulses, (e == 6) ? 7'b0000100 : 7'b0);
      chk("down_pre_held", e, held, (e >= 5) ? 7'b0000100 : 7'b0);
    end
    reset = 1'b0;
    #1;
    chk("async_rst_pulses", 14, pulses, 7'b0);
    chk("async_rst_held", 14, held, 7'b0);
    chk("async_rst_al_held", 14, al_held, 7'b0);
    for (int e = 15; e < 18; e++) begin
      tick();
      chk("in_rst_pulses", e, pulses, 7'b0);
      chk("in_rst_held", e, held, 7'b0);
    end
    reset = 1'b1;
    // Internal logic first runs at edge 20, so the fresh press pulses at 26
    for (int e = 18; e < 36; e++) begin
      tick();
      chk("down_post_pulse", e, pulses, (e == 26) ? 7'b0000100 : 7'b0);
      chk("down_post_held", e, held, (e >= 25) ? 7'b0000100 : 7'b0);
    end
    for (int e = 36; e < 51; e++) begin
      raw_down = 1'b0;
      tick();
      chk("down_rel_pulse", e, pulses, 7'b0);
      chk("down_rel_held", e, held, (e <= 40) ? 7'b0000100 : 7'b0);
    end
    idle(4);

    // Active-low instance: raw_start driven low from edge 0 for 10 cycles
    for (int e = 0; e < 25; e++) begin
      al_start = !(e < 10);
      tick();
      chk("al_start_pulse", e, al_pulses, (e == 6) ? 7'b1000000 : 7'b0);
      chk("al_start_held", e, al_held, (e >= 5 && e <= 14) ? 7'b1000000 : 7'b0);
      chk("al_main_quiet", e, pulses, 7'b0);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized cycles required to accept a level change.
REQ-002 Parameter REPEAT_DELAY, default 25000000, meaning hold cycles before the first auto-repeat of a direction pulse.
REQ-003 Parameter REPEAT_RATE, default 10000000, meaning cycles between subsequent auto-repeat direction pulses.
REQ-004 Parameter RAW_ACTIVE_LOW, default 0, meaning raw pins are inverted before synchronization when 1.
REQ-005 clk  input  1  single system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 raw_start, raw_a, raw_b, raw_up, raw_down, raw_left, raw_right  input  1 each  asynchronous board pins.
REQ-008 start_button, a_button, b_button, up_button, down_button, left_button, right_button  output  1 each  registered single-cycle press pulses driving the game FSM inputs of the same names.
REQ-009 held  output  7  debounced levels {start,a,b,up,down,left,right}, MSB = start.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL keep a debounced level; a counter increments while the synchronized value differs from that level, clears when equal, and the level flips on the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-012 A press pulse SHALL be high for exactly one cycle, on the cycle after the debounced level rises; a debounced fall SHALL never produce a pulse.
REQ-013 Latency: raw held high from edge N SHALL produce the pulse at edge N+2+DEBOUNCE_CYCLES.
REQ-014 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and leave held unchanged.
REQ-015 start, a and b SHALL never auto-repeat.
REQ-016 Each direction button SHALL run a per-button repeat FSM with states IDLE, DELAY, REPEAT: IDLE->DELAY on debounced press (emit initial pulse); DELAY->REPEAT after REPEAT_DELAY held cycles (emit pulse); in REPEAT emit one pulse every REPEAT_RATE held cycles; any state->IDLE on debounced release, with counters cleared.
REQ-017 Repeat counters SHALL saturate rather than wrap and SHALL be wide enough for max(REPEAT_DELAY, REPEAT_RATE).
REQ-018 At most one direction output SHALL pulse per cycle; priority up > down > left > right; a lower-priority pulse that is suppressed is dropped, not deferred.
REQ-019 start, a and b pulses SHALL be independent of each other and of direction pulses.
REQ-020 A button still pressed when reset deasserts SHALL produce one pulse after DEBOUNCE_CYCLES, as a fresh press.

Reset
REQ-021 On reset low, all synchronizer flops, debounced levels, counters and pulse outputs SHALL clear to 0 and all repeat FSMs SHALL enter IDLE, immediately and without a clock.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abort the operation; no pulse is emitted during or on the first edge after reset.
REQ-023 Reset deassertion SHALL be synchronized to clk before release of internal state.

Structure
REQ-024 The button index enumeration (START..RIGHT) and repeat-FSM state encoding SHALL live in the shared sudoku package.
REQ-025 One sub-module, btn_debounce (synchronizer + debounce counter + edge pulse), SHALL be instantiated seven times; repeat FSMs and the priority mux reside in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-026 raw_a high from edge 10, held 50 cycles -> a_button high only at edge 16, held[5]=1 from edge 15.
REQ-027 raw_up pulsed high for 3 cycles -> no up_button pulse, held[3] stays 0.
REQ-028 raw_right held 60 cycles from edge 0 -> right_button pulses at edges 6, 26, 34, 42, 50, 58; none after release.
REQ-029 raw_up and raw_left rise on the same edge -> up_button pulses at edge 6, left_button stays 0 that cycle.
REQ-030 raw_down held, reset low at edge 15 for 3 cycles -> all outputs 0 immediately; down_button pulses again 2+DEBOUNCE_CYCLES edges after the synchronized release of reset.
REQ-031 RAW_ACTIVE_LOW=1, raw_start driven 1->0 -> start_button pulses once, 6 edges later.
